// File: rtl/microwave_cook_ctrl_if.sv
// Front-panel and display bundle between the oven panel logic and the cook controller.
// The panel side drives keypad/buttons/door; the controller drives the digits and status.
interface microwave_cook_ctrl_if;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens_bcd;
    logic [3:0] sec_ones_bcd;
    logic       mag_on;
    logic [2:0] state;
    logic       done;

    modport master (
        output keypad, startn, stopn, door_closed,
        input  min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, state, done
    );

    modport slave (
        input  keypad, startn, stopn, door_closed,
        output min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, state, done
    );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook-cycle controller: keypad m:ss entry, start/stop/door sequencing
// and a once-per-second BCD countdown that gates the magnetron.
module microwave_cook_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned PRESC_W       = 7
) (
    input  logic                 clk,
    input  logic                 clearn,
    microwave_cook_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_e;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_time_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_e             state_q;
    bcd_time_t          time_q;
    logic [PRESC_W-1:0] presc_q;
    logic               mag_on_q;
    logic               done_q;
    logic               startn_q;
    logic               stopn_q;
    logic [9:0]         keypad_q;

    logic       start_ev;
    logic       stop_ev;
    logic       key_ev;
    logic [3:0] key_digit_d;
    logic [3:0] key_hits_d;
    bcd_time_t  time_dec_d;
    logic       time_zero;
    logic       dec_zero;

    assign start_ev = startn_q & ~bus.startn;
    assign stop_ev  = stopn_q & ~bus.stopn;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        key_digit_d = 4'd0;
        key_hits_d  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.keypad[i]) begin
                key_digit_d = 4'(i);
                key_hits_d  = key_hits_d + 4'd1;
            end
        end
    end

    assign key_ev = (keypad_q == 10'd0) && (key_hits_d == 4'd1);

    always_comb begin
        time_dec_d = time_q;
        if (time_q.ones != 4'd0) begin
            time_dec_d.ones = time_q.ones - 4'd1;
        end else begin
            time_dec_d.ones = 4'd9;
            if (time_q.tens != 4'd0) begin
                time_dec_d.tens = time_q.tens - 4'd1;
            end else begin
                time_dec_d.tens = 4'd5;
                time_dec_d.min  = time_q.min - 4'd1;
            end
        end
    end

    assign time_zero = (time_q == '0);
    assign dec_zero  = (time_dec_d == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q  <= IDLE;
            time_q   <= '0;
            presc_q  <= '0;
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
            // History follows the live inputs so a button held through reset is not a press.
            startn_q <= bus.startn;
            stopn_q  <= bus.stopn;
            keypad_q <= bus.keypad;
        end else begin
            startn_q <= bus.startn;
            stopn_q  <= bus.stopn;
            keypad_q <= bus.keypad;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    mag_on_q <= 1'b0;
                    if (stop_ev) begin
                        time_q <= '0;
                    end else if (start_ev) begin
                        if (bus.door_closed && !time_zero) begin
                            state_q  <= COOK;
                            presc_q  <= '0;
                            mag_on_q <= 1'b1;
                        end
                    end else if (key_ev) begin
                        time_q <= '{min: time_q.tens, tens: time_q.ones, ones: key_digit_d};
                    end
                end
                COOK: begin
                    // Door or stop beats a same-cycle decrement and drops the magnetron on this edge.
                    if (stop_ev || !bus.door_closed) begin
                        state_q  <= PAUSE;
                        mag_on_q <= 1'b0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                        time_q  <= time_dec_d;
                        if (dec_zero) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            mag_on_q <= 1'b0;
                        end
                    end else begin
                        presc_q <= presc_q + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    mag_on_q <= 1'b0;
                    if (stop_ev) begin
                        state_q <= IDLE;
                        time_q  <= '0;
                    end else if (start_ev && bus.door_closed) begin
                        state_q  <= COOK;
                        presc_q  <= '0;
                        mag_on_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    mag_on_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mag_on_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_bcd      = time_q.min;
    assign bus.sec_tens_bcd = time_q.tens;
    assign bus.sec_ones_bcd = time_q.ones;
    assign bus.mag_on       = mag_on_q;
    assign bus.state        = state_q;
    assign bus.done         = done_q;

endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
Cooking-cycle controller and timer datapath for the microwave oven. It captures keypad digits into a 3-digit BCD m:ss time register and sequences idle, cooking, paused and done phases from startn, stopn and door_closed. It decrements the time once per second while cooking and drives mag_on. BCD outputs feed the existing 7-segment decoders (min, sec tens, sec ones).

Parameters:
TICKS_PER_SEC, 100, clk cycles per 1 s countdown step (100 for 10 ms clk); legal range is 2 or more.
PRESC_W, 7, width of the prescaler counter; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clearn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
keypad  input  10  one-hot digit keys; bit n = digit n.
startn  input  1  start button, active-low level.
stopn  input  1  stop/clear button, active-low level.
door_closed  input  1  1 = door closed.
min_bcd  output  4  minutes digit, BCD.
sec_tens_bcd  output  4  seconds tens digit, BCD.
sec_ones_bcd  output  4  seconds ones digit, BCD.
mag_on  output  1  magnetron enable; registered.
state  output  3  current FSM state code.
done  output  1  one-cycle pulse when a cook cycle completes.

Behaviour:
- Reset (clearn=0 at a clock edge):
  - state=IDLE; all BCD digits=0; mag_on=0; done=0; prescaler=0.
  - Edge-detect history registers are loaded so that buttons held at reset are not seen as presses.
  - Reset mid-cook drops mag_on on that same edge.
- Press detection, registered previous-sample history:
  - start_ev = startn 1→0; stop_ev = stopn 1→0.
  - key_ev = keypad goes from all-zero to exactly one bit set.
  - Multi-hot values and changes from one nonzero value to another are ignored.
  - Digits 0-9 are accepted as-is; no lookup table.
- States and codes: IDLE=0, COOK=1, PAUSE=2, DONE=3.
- IDLE:
  - key_ev shifts the time left: min←sec_tens, sec_tens←sec_ones, sec_ones←digit. The old min digit is discarded.
  - stop_ev clears all digits to 0.
  - start_ev with door_closed=1 and time≠0:00 → COOK and clears the prescaler.
  - start_ev with the door open or time 0:00 is ignored.
- COOK:
  - mag_on=1, registered, so it is asserted the cycle after entry.
  - The prescaler counts 0..TICKS_PER_SEC-1. At terminal count it wraps to 0 and issues a decrement.
  - The first decrement occurs exactly TICKS_PER_SEC cycles after the entry edge.
  - Keypad input is ignored.
- Decrement, BCD with borrow:
  - sec_ones 0→9 with a borrow into tens; else ones-1.
  - sec_tens 0→5 with a borrow into min; else tens-1. Tens values above 5 entered from the keypad decrement normally (9→8).
  - A decrement that yields 0:00 sets done=1 for one cycle, goes to DONE, and deasserts mag_on.
- PAUSE:
  - Entered from COOK on door_closed=0 or stop_ev; mag_on→0 and the time is held.
  - start_ev with door_closed=1 → COOK; the prescaler restarts from 0.
  - stop_ev in PAUSE clears the time to 0:00 → IDLE.
  - Keypad input is ignored.
- DONE: lasts one cycle, then goes to IDLE. The time reads 0:00.
- Simultaneous events in COOK:
  - Door open or stop_ev takes priority over a decrement in the same cycle; no decrement occurs.
  - stop_ev wins over start_ev in every state.
  - In IDLE, key_ev together with start_ev: start is evaluated on the pre-shift time and the key is discarded.
- mag_on must never be 1 in a cycle whose registered door_closed sample was 0. The transition to PAUSE and mag_on=0 occur on the same edge that samples the door open.
- done and mag_on are never 1 in the same cycle.

Test Plan:
- TICKS_PER_SEC=4; reset, then keys 2,5,9 (each 0→one-hot→0) → min=2, tens=5, ones=9, state=IDLE, mag_on=0.
- Keys 1,0,5, door closed, startn pulse → state=COOK. 4 cycles after entry, time=1:04. Run until 0:59→0:58 and 1:00→0:59 borrow occur; at 0:00 done pulses exactly 1 cycle, mag_on=0, state→IDLE.
- Time 0:30, door_closed=0, startn pulse → stays IDLE, mag_on=0. Close the door and pulse startn → COOK.
- During COOK at 0:20, drop door_closed on the prescaler terminal cycle → PAUSE, time stays 0:20 (no decrement), mag_on=0 the next cycle. Close the door and start → COOK; the next decrement comes 4 cycles later to 0:19.
- In COOK, stopn pulse → PAUSE, hold; a second stopn pulse → IDLE with 0:00. Keypad 0x003 (multi-hot) in IDLE → no change.
- Assert clearn=0 mid-COOK at 0:45 → on the next edge state=IDLE, 0:00, mag_on=0, done=0. startn held low through reset does not trigger a start.
